// File: rtl/ecc_counter_scrubber_if.sv
// ecc_counter_scrubber_if: control, injection and status signals of the
// ECC-protected counter. The master side drives commands, the slave side
// is the counter block itself.
interface ecc_counter_scrubber_if #(
  parameter int WIDTH = 32
);
  localparam int BLOCKS = WIDTH / 4;
  localparam int PBITS  = 3 * BLOCKS;

  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             scrub_req;
  logic             inj_en;
  logic [WIDTH-1:0] inj_data_mask;
  logic [PBITS-1:0] inj_par_mask;
  logic [WIDTH-1:0] counter;
  logic             busy;
  logic             err_corrected;
  logic [7:0]       err_count;
  logic             err_uncorrectable;

  modport master (
    output enable, up_down, load, load_value, scrub_req,
           inj_en, inj_data_mask, inj_par_mask,
    input  counter, busy, err_corrected, err_count, err_uncorrectable
  );

  modport slave (
    input  enable, up_down, load, load_value, scrub_req,
           inj_en, inj_data_mask, inj_par_mask,
    output counter, busy, err_corrected, err_count, err_uncorrectable
  );
endinterface

// File: rtl/ecc_counter_scrubber.sv
// ecc_counter_scrubber: up/down counter whose storage is protected by a
// Hamming(7,4) code on every nibble. A scrub (periodic after SCRUB_PERIOD
// idle cycles, or on scrub_req) checks all nibbles in one cycle and writes
// back single-bit corrections for all of them in the next.
// Build macro ECC_COUNTER_DED_EN adds an overall-parity bit per nibble so
// double errors are detected, left unmodified and flagged sticky.
module ecc_counter_scrubber #(
  parameter int WIDTH        = 32,
  parameter int SCRUB_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_counter_scrubber_if.slave bus
);
  localparam int BLOCKS = WIDTH / 4;
  localparam int PBITS  = 3 * BLOCKS;
  localparam int TW     = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'((SCRUB_PERIOD > 0) ? SCRUB_PERIOD - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, CORRECT = 2'd2} state_t;

  function automatic logic [2:0] hamming_enc(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  function automatic logic [PBITS-1:0] encode_all(input logic [WIDTH-1:0] d);
    logic [PBITS-1:0] p;
    p = '0;
    for (int i = 0; i < BLOCKS; i++) p[3*i +: 3] = hamming_enc(d[4*i +: 4]);
    return p;
  endfunction

  // Syndrome -> {data flips d3..d0, parity flips p2..p0}
  function automatic logic [6:0] flip_map(input logic [2:0] s);
    case (s)
      3'b110:  return 7'b1000_000;
      3'b101:  return 7'b0100_000;
      3'b011:  return 7'b0010_000;
      3'b111:  return 7'b0001_000;
      3'b100:  return 7'b0000_100;
      3'b010:  return 7'b0000_010;
      3'b001:  return 7'b0000_001;
      default: return 7'b0000_000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              state, state_next;
  logic [WIDTH-1:0]    data, upd_data, idle_data, fix_data;
  logic [PBITS-1:0]    parity, idle_par, fix_par, synd_now, synd_p1;
  logic [7*BLOCKS-1:0] flips;
  logic [BLOCKS-1:0]   skip;
  logic [TW-1:0]       timer;
  logic [7:0]          err_cnt;
  logic                write_new, activity, idle_expire, scrub_go, fix_any;

`ifdef ECC_COUNTER_DED_EN
  function automatic logic [BLOCKS-1:0] overall_all(input logic [WIDTH-1:0] d);
    logic [BLOCKS-1:0] o;
    o = '0;
    for (int i = 0; i < BLOCKS; i++) o[i] = ^{d[4*i +: 4], hamming_enc(d[4*i +: 4])};
    return o;
  endfunction

  logic [BLOCKS-1:0] ovr, fix_ovr, dbl_now, dbl_p1;
  logic              unc;
`endif

  assign synd_now    = parity ^ encode_all(data);
  assign write_new   = bus.load | bus.enable;
  assign activity    = write_new | bus.inj_en;
  assign idle_expire = (SCRUB_PERIOD != 0) && !activity && (timer == TIMER_MAX);
  assign scrub_go    = bus.scrub_req | idle_expire;

  // Count/load result before injection; load wins over enable
  always_comb begin
    upd_data = data;
    if (bus.load)        upd_data = bus.load_value;
    else if (bus.enable) upd_data = bus.up_down ? data + WIDTH'(1) : data - WIDTH'(1);
  end

  assign idle_data = upd_data ^ (bus.inj_en ? bus.inj_data_mask : {WIDTH{1'b0}});
  assign idle_par  = (write_new ? encode_all(upd_data) : parity)
                     ^ (bus.inj_en ? bus.inj_par_mask : {PBITS{1'b0}});

`ifdef ECC_COUNTER_DED_EN
  // A nonzero syndrome with consistent overall parity means two bits flipped
  always_comb begin
    dbl_now = '0;
    for (int b = 0; b < BLOCKS; b++)
      dbl_now[b] = (synd_now[3*b +: 3] != 3'b000) && !(^{data[4*b +: 4], parity[3*b +: 3], ovr[b]});
  end
  assign skip = dbl_p1;
`else
  assign skip = '0;
`endif

  // Per-block flip pattern decoded from the registered syndromes
  always_comb begin
    flips = '0;
    for (int b = 0; b < BLOCKS; b++) flips[7*b +: 7] = flip_map(synd_p1[3*b +: 3]);
  end

  // Corrected image of the whole word, written back in CORRECT
  always_comb begin
    fix_data = data;
    fix_par  = parity;
    fix_any  = 1'b0;
    for (int b = 0; b < BLOCKS; b++) begin
      if (!skip[b] && (flips[7*b +: 7] != 7'd0)) begin
        fix_data[4*b +: 4] = data[4*b +: 4] ^ flips[7*b+3 +: 4];
        fix_par[3*b +: 3]  = parity[3*b +: 3] ^ flips[7*b +: 3];
        fix_any            = 1'b1;
      end
    end
  end

`ifdef ECC_COUNTER_DED_EN
  // Overall parity is re-derived only for blocks that get corrected
  always_comb begin
    fix_ovr = ovr;
    for (int b = 0; b < BLOCKS; b++)
      if (!dbl_p1[b] && (synd_p1[3*b +: 3] != 3'b000))
        fix_ovr[b] = ^{fix_data[4*b +: 4], fix_par[3*b +: 3]};
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (scrub_go) state_next = CHECK;
      CHECK:   state_next = (synd_now != '0) ? CORRECT : IDLE;
      CORRECT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy          = (state != IDLE);
    bus.err_corrected = (state == CORRECT) && fix_any;
  end

  // Storage, idle timer and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      parity  <= '0;
      timer   <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          data   <= idle_data;
          parity <= idle_par;
          if (scrub_go || activity) timer <= '0;
          else                      timer <= timer + TW'(1);
        end
        CORRECT: begin
          data   <= fix_data;
          parity <= fix_par;
          if (fix_any) err_cnt <= sat_inc(err_cnt);
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: syndromes captured in CHECK, consumed in CORRECT ----
  // Syndrome snapshot taken during CHECK
  always_ff @(posedge clk) begin
    if (state == CHECK) begin
      synd_p1 <= synd_now;
`ifdef ECC_COUNTER_DED_EN
      dbl_p1  <= dbl_now;
`endif
    end
  end

`ifdef ECC_COUNTER_DED_EN
  // Overall-parity storage and sticky double-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr <= '0;
      unc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write_new) ovr <= overall_all(upd_data);
          if (bus.load)  unc <= 1'b0;
        end
        CORRECT: begin
          ovr <= fix_ovr;
          if (dbl_p1 != '0) unc <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.err_uncorrectable = unc;
`else
  assign bus.err_uncorrectable = 1'b0;
`endif

  assign bus.counter   = data;
  assign bus.err_count = err_cnt;
endmodule
